iic_module: RTL and testbench

//  Single-byte I2C (IIC) bus master. On a start request it issues START, 7-bit address + R/W,

---
 rtl/iic_module.sv | 270 +++++++++++++++++++++++++++
 tb/tb_iic_module.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iic_module.sv
// Purpose : single-byte I2C master; START, {addr,RW}, one data byte, STOP.
// Latency : transfer starts 2 clocks after i_start rises; one SCL bit = 4*Q clocks.
// Backpr. : none; start edges while busy are dropped; no clock stretching.
//
// Ports
//   i_clk, i_rst         clock, synchronous active-high reset
//   i_start              rising edge (after registering) launches a transfer
//   i_RW, i_W_byte       direction (1 = read) and byte to write
//   i_mode               0 = standard SCL rate, 1 = fast SCL rate
//   i_address            7-bit slave address
//   o_SDA, o_SCL         open-drain bus pins, driven 0 or released (z)
//   o_R_byte             last byte read; held until the next read completes
//   o_LED1..o_LED4       busy, done-ok (sticky), NACK error (sticky), latched mode
module iic_module #(
    parameter int CLK_HZ = 50_000_000,
    parameter int F_STD  = 100_000,
    parameter int F_FAST = 400_000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_RW,
    input  logic [7:0] i_W_byte,
    input  logic       i_mode,
    input  logic [6:0] i_address,
    inout  wire        o_SDA,
    output wire        o_SCL,
    output logic [7:0] o_R_byte,
    output logic       o_LED1,
    output logic       o_LED2,
    output logic       o_LED3,
    output logic       o_LED4
);

    // Quarter-period lengths, integer-truncated (125 / 31 at the defaults).
    localparam int Q_STD  = CLK_HZ / (4 * F_STD);
    localparam int Q_FAST = CLK_HZ / (4 * F_FAST);
    localparam int Q_MAX  = (Q_STD > Q_FAST) ? Q_STD : Q_FAST;
    localparam int DIV_W  = (Q_MAX > 1) ? $clog2(Q_MAX) : 1;

    localparam logic [DIV_W-1:0] QL_STD  = DIV_W'(Q_STD - 1);
    localparam logic [DIV_W-1:0] QL_FAST = DIV_W'(Q_FAST - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_ADDR,
        ST_ACK1,
        ST_WDATA,
        ST_RDATA,
        ST_ACK2,
        ST_STOP
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       qtr;        // quarter within the current bit / phase
    logic [2:0]       bit_cnt;    // bit index within a byte
    logic             start_s1;
    logic             start_s2;
    logic             start_edge;
    logic             rw_q;
    logic             mode_q;
    logic [7:0]       wbyte_q;
    logic [7:0]       tx_shift;   // MSB is the bit currently on SDA
    logic [7:0]       rx_shift;
    logic             ack_smp;    // last SDA sample; 1 means released/high
    logic [7:0]       r_byte;
    logic             led2;
    logic             led3;

    logic             qtick;
    logic [DIV_W-1:0] q_last;
    logic             sda_high;
    logic             sda_low;
    logic             scl_low;

    assign start_edge = start_s1 & ~start_s2;
    assign q_last     = mode_q ? QL_FAST : QL_STD;
    assign qtick      = (div_cnt == q_last);

    // Anything other than a clean 0 (pulled-up 1 or floating z) counts as high,
    // so an absent slave reads as NACK.
    assign sda_high = (o_SDA !== 1'b0);

    assign o_SDA = sda_low ? 1'b0 : 1'bz;
    assign o_SCL = scl_low ? 1'b0 : 1'bz;

    assign o_R_byte = r_byte;
    assign o_LED1   = (state != ST_IDLE);
    assign o_LED2   = led2;
    assign o_LED3   = led3;
    assign o_LED4   = mode_q;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and bus pin decode
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        sda_low   = 1'b0;
        scl_low   = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (start_edge) begin
                    state_nxt = ST_START;
                end
            end

            // q0 both released, q1 SDA low (START condition), q2 SCL low.
            ST_START: begin
                sda_low = (qtr != 2'd0);
                scl_low = (qtr == 2'd2);
                if (qtick && qtr == 2'd2) begin
                    state_nxt = ST_ADDR;
                end
            end

            ST_ADDR: begin
                scl_low = ~qtr[1];
                sda_low = ~tx_shift[7];
                if (qtick && qtr == 2'd3 && bit_cnt == 3'd7) begin
                    state_nxt = ST_ACK1;
                end
            end

            // SDA released; the sample taken at the end of q2 decides the path.
            ST_ACK1: begin
                scl_low = ~qtr[1];
                if (qtick && qtr == 2'd3) begin
                    if (ack_smp) begin
                        state_nxt = ST_STOP;
                    end else if (rw_q) begin
                        state_nxt = ST_RDATA;
                    end else begin
                        state_nxt = ST_WDATA;
                    end
                end
            end

            ST_WDATA: begin
                scl_low = ~qtr[1];
                sda_low = ~tx_shift[7];
                if (qtick && qtr == 2'd3 && bit_cnt == 3'd7) begin
                    state_nxt = ST_ACK2;
                end
            end

            ST_RDATA: begin
                scl_low = ~qtr[1];
                if (qtick && qtr == 2'd3 && bit_cnt == 3'd7) begin
                    state_nxt = ST_ACK2;
                end
            end

            // Write: slave acknowledges. Read: master leaves SDA released (NACK).
            ST_ACK2: begin
                scl_low = ~qtr[1];
                if (qtick && qtr == 2'd3) begin
                    state_nxt = ST_STOP;
                end
            end

            // q0 SDA low with SCL released, q1 SDA released (STOP condition).
            ST_STOP: begin
                sda_low = (qtr == 2'd0);
                if (qtick && qtr == 2'd1) begin
                    state_nxt = ST_IDLE;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Timing counters, shift registers and status
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            start_s1 <= 1'b0;
            start_s2 <= 1'b0;
            div_cnt  <= '0;
            qtr      <= '0;
            bit_cnt  <= '0;
            rw_q     <= 1'b0;
            mode_q   <= 1'b0;
            wbyte_q  <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
            ack_smp  <= 1'b0;
            r_byte   <= '0;
            led2     <= 1'b0;
            led3     <= 1'b0;
        end else begin
            start_s1 <= i_start;
            start_s2 <= start_s1;

            if (state == ST_IDLE) begin
                div_cnt <= '0;
                qtr     <= '0;
                bit_cnt <= '0;
                if (start_edge) begin
                    rw_q     <= i_RW;
                    mode_q   <= i_mode;
                    wbyte_q  <= i_W_byte;
                    tx_shift <= {i_address, i_RW};
                    led2     <= 1'b0;
                    led3     <= 1'b0;
                end
            end else begin
                div_cnt <= qtick ? '0 : div_cnt + 1'b1;

                if (qtick) begin
                    // Every phase restarts at q0; inside a byte the 2-bit count wraps.
                    qtr <= (state_nxt != state) ? 2'd0 : qtr + 2'd1;

                    // End of q2 is the SCL-high sample point.
                    if (qtr == 2'd2) begin
                        ack_smp <= sda_high;
                        if (state == ST_RDATA) begin
                            rx_shift <= {rx_shift[6:0], sda_high};
                        end
                    end

                    if (qtr == 2'd3) begin
                        if (state inside {ST_ADDR, ST_WDATA, ST_RDATA}) begin
                            bit_cnt  <= bit_cnt + 3'd1;
                            tx_shift <= {tx_shift[6:0], 1'b1};
                        end
                        if (state == ST_ACK1) begin
                            if (ack_smp) begin
                                led3 <= 1'b1;
                            end
                            tx_shift <= wbyte_q;
                        end
                        if (state == ST_ACK2) begin
                            if (rw_q) begin
                                r_byte <= rx_shift;
                            end else if (ack_smp) begin
                                led3 <= 1'b1;
                            end
                        end
                    end

                    // Leaving STOP: done is the complement of the sticky NACK flag.
                    if (state == ST_STOP && qtr == 2'd1) begin
                        led2 <= ~led3;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_iic_module.sv
`timescale 1ns/1ps
module tb_iic_module;

    localparam int CLK_HZ = 50_000_000;
    localparam int F_STD  = 100_000;
    localparam int F_FAST = 400_000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       rw = 1'b0;
    logic [7:0] wbyte = 8'h00;
    logic       mode = 1'b0;
    logic [6:0] addr = 7'h00;
    wire        sda;
    wire        scl;
    logic [7:0] rbyte;
    logic       led1, led2, led3, led4;

    // Slave-side open-drain driver and bus pull-ups.
    logic slv_low = 1'b0;
    assign sda = slv_low ? 1'b0 : 1'bz;
    pullup pu_sda (sda);
    pullup pu_scl (scl);

    iic_module #(.CLK_HZ(CLK_HZ), .F_STD(F_STD), .F_FAST(F_FAST)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_RW(rw), .i_W_byte(wbyte),
        .i_mode(mode), .i_address(addr), .o_SDA(sda), .o_SCL(scl), .o_R_byte(rbyte),
        .o_LED1(led1), .o_LED2(led2), .o_LED3(led3), .o_LED4(led4)
    );

    initial forever #10 clk = ~clk;

    // Scoreboard counters
    int checks = 0;
    int fails  = 0;

    // Bus observations (grow monotonically; transfers take baselines)
    int   cyc = 0;
    logic bits[$];
    int   rise_t[$];
    int   stops = 0;
    int   xfers = 0;

    // Behavioural model of the idle-time outputs
    logic       mdl_valid = 1'b0;
    logic       m_led2 = 1'b0, m_led3 = 1'b0, m_led4 = 1'b0;
    logic [7:0] m_rbyte = 8'h00;
    logic       cur_mode = 1'b0;

    // Slave personality for the current transfer
    logic       slv_present = 1'b0;
    logic       slv_rw = 1'b0;
    logic       slv_ack2 = 1'b0;
    logic [7:0] slv_rd = 8'h00;
    int         slv_q = 125;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic wait_led1(input logic v, input int budget, input string nm);
        int n = 0;
        while (led1 !== v && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(nm, led1, v);
    endtask

    // Bus decoder plus per-cycle comparison against the model.
    task automatic monitor_loop();
        logic scl_q = 1'b1, sda_q = 1'b1, led1_q = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (scl && !scl_q) begin
                bits.push_back(sda);
                rise_t.push_back(cyc);
            end
            if (scl && scl_q && sda && !sda_q) stops++;
            if (led1 && !led1_q) xfers++;
            if (!rst) begin
                if (led1) begin
                    chk("busy_led2", led2, 1'b0);
                    chk("busy_led4", led4, cur_mode);
                end else if (mdl_valid) begin
                    chk("idle_led2", led2, m_led2);
                    chk("idle_led3", led3, m_led3);
                    chk("idle_led4", led4, m_led4);
                    chk("idle_rbyte", rbyte, m_rbyte);
                    chk("idle_scl_released", scl, 1'b1);
                    chk("idle_sda_released", sda, 1'b1);
                end
            end
            scl_q  = scl;
            sda_q  = sda;
            led1_q = led1;
        end
    endtask

    // Slave: counts SCL falling edges; edge k>=2 starts bit k-1, edge 1 starts bit 0.
    task automatic slave_loop();
        logic scl_q = 1'b1;
        int   falls = 0;
        int   rel = 0;
        forever begin
            @(negedge clk);
            if (!led1) begin
                falls   = 0;
                rel     = 0;
                slv_low = 1'b0;
            end else begin
                if (scl_q && !scl) begin
                    falls++;
                    if (falls == 9)
                        slv_low = slv_present;
                    else if (falls >= 10 && falls <= 17)
                        slv_low = slv_present && slv_rw && !slv_rd[17 - falls];
                    else if (falls == 18)
                        slv_low = slv_present && !slv_rw && slv_ack2;
                    else
                        slv_low = 1'b0;
                end
                // No SCL fall follows ACK2; let go once STOP has pulled SDA low.
                if (!scl_q && scl && falls == 18 && slv_low) rel = 2 * slv_q + slv_q / 2;
                if (rel > 0) begin
                    rel--;
                    if (rel == 0) slv_low = 1'b0;
                end
            end
            scl_q = scl;
        end
    endtask

    task automatic do_xfer(input logic rw_i, input logic mode_i, input logic [6:0] a_i,
                           input logic [7:0] wb_i, input logic pres_i, input logic ack2_i,
                           input logic [7:0] rd_i, output logic [7:0] got_addr,
                           output logic [7:0] got_data, output int period);
        int b0, r0, s0, nb, q;
        q = CLK_HZ / (4 * (mode_i ? F_FAST : F_STD));
        slv_present = pres_i; slv_rw = rw_i; slv_ack2 = ack2_i; slv_rd = rd_i; slv_q = q;
        rw = rw_i; mode = mode_i; addr = a_i; wbyte = wb_i; cur_mode = mode_i;
        b0 = bits.size(); r0 = rise_t.size(); s0 = stops;
        got_addr = 8'h00; got_data = 8'h00; period = 0;
        start = 1'b1;
        wait_led1(1'b1, 20, "launch");
        mdl_valid = 1'b0;
        // Inputs are latched; changing them now must not matter.
        rw = 1'($urandom); mode = 1'($urandom); addr = 7'($urandom); wbyte = 8'($urandom);
        repeat (4) @(negedge clk);
        start = 1'b0;
        wait_led1(1'b0, 25 * 4 * q + 200, "complete");
        nb = pres_i ? 18 : 9;
        chk("bit_count", bits.size() - b0, nb);
        chk("stop_count", stops - s0, 1);
        if (bits.size() >= b0 + nb) begin
            for (int i = 0; i < 8; i++) got_addr = {got_addr[6:0], bits[b0 + i]};
            chk("addr_byte", got_addr, {a_i, rw_i});
            chk("ack1_bit", bits[b0 + 8], !pres_i);
            if (pres_i) begin
                for (int i = 0; i < 8; i++) got_data = {got_data[6:0], bits[b0 + 9 + i]};
                chk("data_byte", got_data, rw_i ? rd_i : wb_i);
                chk("ack2_bit", bits[b0 + 17], rw_i ? 1'b1 : !ack2_i);
            end
        end
        if (rise_t.size() >= r0 + 2) period = rise_t[r0 + 1] - rise_t[r0];
        chk("scl_period", period, 4 * q);
        m_led3 = !pres_i || (!rw_i && !ack2_i);
        m_led2 = !m_led3;
        m_led4 = mode_i;
        if (pres_i && rw_i) m_rbyte = rd_i;
        mdl_valid = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        logic [7:0] ga, gd;
        int per, x0;
        fork
            monitor_loop();
            slave_loop();
        join_none

        // 1: reset state
        repeat (5) @(negedge clk);
        chk("rst_scl", scl, 1'b1);
        chk("rst_sda", sda, 1'b1);
        chk("rst_leds", {led1, led2, led3, led4}, 4'b0000);
        chk("rst_rbyte", rbyte, 8'h00);
        rst = 1'b0;
        mdl_valid = 1'b1;
        repeat (5) @(negedge clk);

        // 2: standard-mode write, slave acknowledges
        do_xfer(1'b0, 1'b0, 7'b1001111, 8'hA5, 1'b1, 1'b1, 8'h00, ga, gd, per);
        chk("t2_addr", ga, 8'h9E);
        chk("t2_data", gd, 8'hA5);
        chk("t2_period", per, 500);
        chk("t2_led", {led1, led2, led3}, 3'b010);

        // 3: standard-mode read returning 0x3C
        do_xfer(1'b1, 1'b0, 7'h4F, 8'h00, 1'b1, 1'b0, 8'h3C, ga, gd, per);
        chk("t3_addr", ga, 8'h9F);
        chk("t3_rbyte", rbyte, 8'h3C);

        // 5: fast-mode write, same byte pattern
        do_xfer(1'b0, 1'b1, 7'b1001111, 8'hA5, 1'b1, 1'b1, 8'h00, ga, gd, per);
        chk("t5_addr", ga, 8'h9E);
        chk("t5_period", per, 124);
        chk("t5_led4", led4, 1'b1);

        // 4: nobody answers the address
        do_xfer(1'b0, 1'b1, 7'h11, 8'h77, 1'b0, 1'b0, 8'h00, ga, gd, per);
        chk("t4_led3", led3, 1'b1);
        chk("t4_led2", led2, 1'b0);
        chk("t4_rbyte_kept", rbyte, 8'h3C);

        // Reset in the middle of the address byte
        slv_present = 1'b1; slv_rw = 1'b1; slv_q = 31;
        rw = 1'b1; mode = 1'b1; addr = 7'h4F; cur_mode = 1'b1;
        start = 1'b1;
        wait_led1(1'b1, 20, "rst_launch");
        mdl_valid = 1'b0;
        repeat (3 * 31 + 2 * 124) @(negedge clk);
        start = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_idle", led1, 1'b0);
        chk("midrst_scl", scl, 1'b1);
        chk("midrst_sda", sda, 1'b1);
        chk("midrst_leds", {led2, led3, led4}, 3'b000);
        chk("midrst_rbyte", rbyte, 8'h00);
        rst = 1'b0;
        m_led2 = 1'b0; m_led3 = 1'b0; m_led4 = 1'b0; m_rbyte = 8'h00;
        mdl_valid = 1'b1;
        repeat (10) @(negedge clk);

        // 6: held / toggled start produces one transfer per edge from idle
        slv_present = 1'b1; slv_rw = 1'b0; slv_ack2 = 1'b1; slv_q = 31;
        rw = 1'b0; mode = 1'b1; addr = 7'h2A; wbyte = 8'h5C; cur_mode = 1'b1;
        x0 = xfers;
        start = 1'b1;
        wait_led1(1'b1, 20, "t6_launch");
        mdl_valid = 1'b0;
        repeat (500) @(negedge clk);
        start = 1'b0; repeat (50) @(negedge clk);
        start = 1'b1; repeat (50) @(negedge clk);
        start = 1'b0; repeat (50) @(negedge clk);
        start = 1'b1;
        wait_led1(1'b0, 4000, "t6_done");
        repeat (200) @(negedge clk);
        chk("t6_one_xfer", xfers - x0, 1);
        m_led2 = 1'b1; m_led3 = 1'b0; m_led4 = 1'b1;
        mdl_valid = 1'b1;
        start = 1'b0;
        repeat (5) @(negedge clk);
        start = 1'b1;
        wait_led1(1'b1, 20, "t6_relaunch");
        mdl_valid = 1'b0;
        wait_led1(1'b0, 4000, "t6_redone");
        mdl_valid = 1'b1;
        repeat (200) @(negedge clk);
        chk("t6_two_xfer", xfers - x0, 2);
        start = 1'b0;
        repeat (5) @(negedge clk);

        // Randomized fast-mode transfers
        for (int n = 0; n < 8; n++) begin
            do_xfer(1'($urandom), 1'b1, 7'($urandom), 8'($urandom),
                    ($urandom_range(0, 3) != 0), 1'($urandom), 8'($urandom), ga, gd, per);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
